prescaled_counter: RTL and testbench
====================================

# prescaled_counter

Parametrised up/down event counter with optional clock prescaler, synchronous clear/load, wrap or saturate boundary mode, compare match and sticky overflow flag. Generalises the single free-running register counter to arbitrary width, direction and boundary policy. Used as the common timer/event-count primitive in peripheral blocks. Count state is exposed directly as an output port.

## Interface
Parameters:
- WIDTH, 8, count register width (2..32)
- PRESCALE_WIDTH, 4, width of prescaler divisor (ignored when prescaler compiled out)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  count-enable; counter and prescaler hold when low
- clear  in  1  synchronous clear of count, prescaler and overflow
- load  in  1  synchronous load of load_value
- load_value  in  WIDTH  value loaded when load=1
- up  in  1  direction: 1 increment, 0 decrement
- saturate  in  1  boundary mode: 1 saturate, 0 wrap
- divisor  in  PRESCALE_WIDTH  tick every divisor+1 enabled cycles
- compare_value  in  WIDTH  match reference
- count  out  WIDTH  current count
- terminal  out  1  count at boundary in current direction (MAX if up, 0 if down)
- match  out  1  count == compare_value
- overflow  out  1  sticky: boundary crossing or saturation attempt occurred

## Operation
- Reset (reset_n=0, async): count=0, prescale counter=0, overflow=0. terminal=1 if up=1 and WIDTH... no: terminal/match are combinational from count (after reset: terminal=!up, match=(compare_value==0)).
- Per-edge priority: clear > load > step > hold.
- clear: count=0, prescale counter=0, overflow=0. Ignores enable.
- load: count=load_value, prescale counter=0; overflow unchanged. Ignores enable.
- step occurs when enable=1 and tick=1 and neither clear nor load.
- Step up: count<MAX -> count+1. count==MAX: wrap mode -> 0, saturate mode -> hold MAX; either way overflow<=1.
- Step down: count>0 -> count-1. count==0: wrap -> MAX, saturate -> hold 0; overflow<=1.
- MAX = 2^WIDTH-1; all arithmetic modulo 2^WIDTH, no carry out beyond overflow.
- terminal = up ? (count==MAX) : (count==0); combinational.
- match combinational, independent of enable.
- Direction/mode changes take effect on the next step; no state reset.

## Timing
- count, overflow: registered, update one edge after qualifying inputs.
- terminal, match: zero-latency combinational from count and up/compare_value.
- Prescaler: internal counter p, 0..divisor. With enable=1: tick=1 when p==divisor, then p<=0; else p<=p+1. enable=0 holds p. divisor=0 -> tick every enabled cycle.
- divisor lowered below current p: p continues to 2^PRESCALE_WIDTH-1, wraps to 0; no tick until p==divisor. Documented, not an error.
- First step after clear/load with divisor=d occurs on the (d+1)th enabled edge.
- reset_n asserted mid-count: all state zero immediately, no clock needed.

## Configuration
- PRESCALED_COUNTER_PRESCALER_EN defined: prescaler instantiated, divisor honoured.
- Undefined: no prescaler state; tick tied to 1; divisor port present but unused; count steps every enabled cycle.

## Structure
- Package counter_pkg: direction constants (CNT_UP=1, CNT_DOWN=0), mode constants (CNT_WRAP=0, CNT_SAT=1), function computing MAX for a width.
- Sub-module counter_prescaler (PRESCALE_WIDTH; clock, reset_n, enable, restart, divisor -> tick), instantiated only under the macro; restart driven by clear|load.

## Test plan
(WIDTH=8, PRESCALE_WIDTH=4, macro defined unless noted)
- Reset then enable=1, up=1, divisor=0, 5 edges -> count=5, terminal=0, overflow=0.
- load_value=0xFE, load; then 3 up steps, saturate=0 -> count 0xFF (terminal=1), 0x00 (overflow=1), 0x01; overflow stays 1 until clear.
- count=0x01, up=0, saturate=1, 3 steps -> 0x00, 0x00, 0x00; overflow=1 after second step; terminal=1.
- divisor=3, enable=1 from count=0 -> count increments on edges 4, 8, 12; enable low for 2 cycles delays next step by 2 edges.
- clear and load both asserted with load_value=0x55 -> count=0; reset_n pulsed low mid-step asynchronously -> count=0, overflow=0 before next edge.
- Macro undefined, divisor=7 -> count increments every enabled edge; compare_value=3 -> match=1 exactly while count==3.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the prescaled event counter.
// Direction and boundary-mode encodings, plus the MAX-value helper.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // All-ones value for a register of the given width (1..32).
  function automatic logic [31:0] cnt_max(input int unsigned width);
    if (width >= 32'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: asserts tick once every divisor+1 enabled cycles.
// The internal counter wraps through its full range if the divisor is lowered
// below the current count; no tick is produced until it comes round again.
module counter_prescaler #(
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [PRESCALE_WIDTH-1:0] divisor,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] p_r;
  logic [PRESCALE_WIDTH-1:0] p_next;

  assign tick = (p_r == divisor);

  // Next prescale count: restart wins, then advance or roll over while enabled.
  always_comb begin
    p_next = p_r;
    if (restart) begin
      p_next = {PRESCALE_WIDTH{1'b0}};
    end else if (enable) begin
      if (tick) begin
        p_next = {PRESCALE_WIDTH{1'b0}};
      end else begin
        p_next = p_r + PRESCALE_WIDTH'(1);
      end
    end else begin
      p_next = p_r;
    end
  end

  // Prescale count register with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_r <= {PRESCALE_WIDTH{1'b0}};
    end else begin
      p_r <= p_next;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Parametrised up/down event counter with wrap/saturate boundary policy,
// compare match and sticky overflow flag.
// Optional prescaler: define PRESCALED_COUNTER_PRESCALER_EN to honour divisor;
// otherwise the counter steps on every enabled cycle and divisor is ignored.
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      up,
  input  logic                      saturate,
  input  logic [PRESCALE_WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0]          compare_value,
  output logic [WIDTH-1:0]          count,
  output logic                      terminal,
  output logic                      match,
  output logic                      overflow
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next;
  logic             overflow_r;
  logic             overflow_next;
  logic             tick;
  logic             step;

`ifdef PRESCALED_COUNTER_PRESCALER_EN
  counter_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .restart (clear | load),
    .divisor (divisor),
    .tick    (tick)
  );
`else
  logic unused_divisor;
  assign unused_divisor = ^divisor;
  assign tick = 1'b1;
`endif

  assign step = enable & tick & ~clear & ~load;

  // Next count/overflow: clear > load > step > hold, with boundary policy.
  always_comb begin
    count_next    = count_r;
    overflow_next = overflow_r;
    if (clear) begin
      count_next    = ZERO;
      overflow_next = 1'b0;
    end else if (load) begin
      count_next = load_value;
    end else if (step) begin
      if (up == CNT_UP) begin
        if (count_r == MAX) begin
          overflow_next = 1'b1;
          count_next    = (saturate == CNT_SAT) ? MAX : ZERO;
        end else begin
          count_next = count_r + WIDTH'(1);
        end
      end else begin
        if (count_r == ZERO) begin
          overflow_next = 1'b1;
          count_next    = (saturate == CNT_SAT) ? ZERO : MAX;
        end else begin
          count_next = count_r - WIDTH'(1);
        end
      end
    end else begin
      count_next    = count_r;
      overflow_next = overflow_r;
    end
  end

  // Count and sticky overflow registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r    <= ZERO;
      overflow_r <= 1'b0;
    end else begin
      count_r    <= count_next;
      overflow_r <= overflow_next;
    end
  end

  assign count    = count_r;
  assign overflow = overflow_r;
  assign terminal = (up == CNT_UP) ? (count_r == MAX) : (count_r == ZERO);
  assign match    = (count_r == compare_value);

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter (WIDTH=8, PRESCALE_WIDTH=4).
// Works with PRESCALED_COUNTER_PRESCALER_EN defined or undefined.
module tb_prescaled_counter;

`ifdef PRESCALED_COUNTER_PRESCALER_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif
  localparam int MAXV = 255;
  localparam int PMOD = 16;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       up;
  logic       saturate;
  logic [3:0] divisor;
  logic [7:0] compare_value;
  logic [7:0] count;
  logic       terminal;
  logic       match;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cnt = 0;
  int m_ovf = 0;
  int m_p   = 0;

  prescaled_counter #(.WIDTH(8), .PRESCALE_WIDTH(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .clear         (clear),
    .load          (load),
    .load_value    (load_value),
    .up            (up),
    .saturate      (saturate),
    .divisor       (divisor),
    .compare_value (compare_value),
    .count         (count),
    .terminal      (terminal),
    .match         (match),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock edge: advance the reference model from the applied inputs,
  // then return at the falling edge ready for sampling and new stimulus.
  task automatic clk_model();
    bit t;
    @(posedge clock);
    if (clear) begin
      m_cnt = 0; m_ovf = 0; m_p = 0;
    end else if (load) begin
      m_cnt = int'(load_value); m_p = 0;
    end else if (enable) begin
      t = PRE ? (m_p == int'(divisor)) : 1'b1;
      m_p = t ? 0 : (m_p + 1) % PMOD;
      if (t) begin
        if (up) begin
          if (m_cnt == MAXV) begin m_ovf = 1; m_cnt = saturate ? MAXV : 0; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_ovf = 1; m_cnt = saturate ? 0 : MAXV; end
          else m_cnt = m_cnt - 1;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0;
    load_value = 8'h00; up = 1'b1; saturate = 1'b0; divisor = 4'd0;
    compare_value = 8'h00;
    #12;
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count got %0h want 00", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    checks++; if (terminal !== 1'b0) begin errors++; $display("FAIL reset_term_up got %0b want 0", terminal); end
    checks++; if (match !== 1'b1) begin errors++; $display("FAIL reset_match got %0b want 1", match); end
    up = 1'b0; #1;
    checks++; if (terminal !== 1'b1) begin errors++; $display("FAIL reset_term_down got %0b want 1", terminal); end
    up = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    m_cnt = 0; m_ovf = 0; m_p = 0;
  endtask

  task automatic test_count_up();
    enable = 1'b1; up = 1'b1; divisor = 4'd0; compare_value = 8'hAA;
    for (int e = 0; e < 5; e++) clk_model();
    checks++; if (count !== 8'd5) begin errors++; $display("FAIL up5_count got %0d want 5", count); end
    checks++; if (terminal !== 1'b0) begin errors++; $display("FAIL up5_term got %0b want 0", terminal); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL up5_ovf got %0b want 0", overflow); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_c [3];
    logic       exp_o [3];
    logic       exp_t [3];
    exp_c = '{8'hFF, 8'h00, 8'h01};
    exp_o = '{1'b0, 1'b1, 1'b1};
    exp_t = '{1'b1, 1'b0, 1'b0};
    load_value = 8'hFE; load = 1'b1; clk_model(); load = 1'b0;
    checks++; if (count !== 8'hFE) begin errors++; $display("FAIL wrap_load got %0h want fe", count); end
    up = 1'b1; saturate = 1'b0; divisor = 4'd0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_model();
      checks++; if (count !== exp_c[i] || overflow !== exp_o[i] || terminal !== exp_t[i]) begin
        errors++; $display("FAIL wrap_step%0d got c=%0h o=%0b t=%0b want c=%0h o=%0b t=%0b",
                           i, count, overflow, terminal, exp_c[i], exp_o[i], exp_t[i]);
      end
    end
    load_value = 8'h10; load = 1'b1; clk_model(); load = 1'b0;
    checks++; if (overflow !== 1'b1 || count !== 8'h10) begin
      errors++; $display("FAIL wrap_ovf_sticky got c=%0h o=%0b want c=10 o=1", count, overflow);
    end
  endtask

  task automatic test_saturate_down();
    logic exp_o [3];
    exp_o = '{1'b0, 1'b1, 1'b1};
    enable = 1'b0;
    clear = 1'b1; clk_model(); clear = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf got %0b want 0", overflow); end
    load_value = 8'h01; load = 1'b1; clk_model(); load = 1'b0;
    up = 1'b0; saturate = 1'b1; divisor = 4'd0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_model();
      checks++; if (count !== 8'h00 || overflow !== exp_o[i] || terminal !== 1'b1) begin
        errors++; $display("FAIL satdn_step%0d got c=%0h o=%0b t=%0b want c=00 o=%0b t=1",
                           i, count, overflow, terminal, exp_o[i]);
      end
    end
  endtask

  task automatic test_prescaler();
    int exp;
    enable = 1'b0; up = 1'b1; saturate = 1'b0; divisor = 4'd3;
    clear = 1'b1; clk_model(); clear = 1'b0;
    enable = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      clk_model();
      exp = PRE ? e / 4 : e;
      checks++; if (int'(count) !== exp) begin
        errors++; $display("FAIL presc_edge%0d got %0d want %0d", e, count, exp);
      end
    end
    enable = 1'b0; clk_model(); clk_model();
    exp = PRE ? 3 : 12;
    checks++; if (int'(count) !== exp) begin errors++; $display("FAIL presc_hold got %0d want %0d", count, exp); end
    enable = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      clk_model();
      exp = PRE ? ((e == 4) ? 4 : 3) : 12 + e;
      checks++; if (int'(count) !== exp) begin
        errors++; $display("FAIL presc_resume%0d got %0d want %0d", e, count, exp);
      end
    end
  endtask

  task automatic test_priority();
    // get overflow set first so clear visibly clears it
    enable = 1'b1; up = 1'b0; saturate = 1'b1; divisor = 4'd0;
    load_value = 8'h00; load = 1'b1; clk_model(); load = 1'b0;
    clk_model();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL prio_setup_ovf got %0b want 1", overflow); end
    load_value = 8'h55; clear = 1'b1; load = 1'b1; clk_model();
    clear = 1'b0; load = 1'b0;
    checks++; if (count !== 8'h00 || overflow !== 1'b0) begin
      errors++; $display("FAIL clear_over_load got c=%0h o=%0b want c=00 o=0", count, overflow);
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; up = 1'b1; saturate = 1'b0; divisor = 4'd0;
    load_value = 8'hFF; load = 1'b1; clk_model(); load = 1'b0;
    clk_model(); clk_model();
    checks++; if (count !== 8'h01 || overflow !== 1'b1) begin
      errors++; $display("FAIL areset_setup got c=%0h o=%0b want c=01 o=1", count, overflow);
    end
    @(posedge clock); #2;
    reset_n = 1'b0; #1;
    checks++; if (count !== 8'h00 || overflow !== 1'b0) begin
      errors++; $display("FAIL areset_async got c=%0h o=%0b want c=00 o=0", count, overflow);
    end
    @(negedge clock);
    reset_n = 1'b1;
    m_cnt = 0; m_ovf = 0; m_p = 0;
  endtask

  task automatic test_match();
    enable = 1'b1; up = 1'b1; saturate = 1'b0; divisor = 4'd7; compare_value = 8'd3;
    clear = 1'b1; clk_model(); clear = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      clk_model();
      checks++; if (int'(count) !== m_cnt || match !== (m_cnt == 3)) begin
        errors++; $display("FAIL match_edge%0d got c=%0d m=%0b want c=%0d m=%0b",
                           e, count, match, m_cnt, (m_cnt == 3));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear    = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 14) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom_range(0, 1));
      saturate = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) divisor = 4'($urandom_range(0, 3));
      load_value    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(253, 255));
      compare_value = 8'($urandom_range(0, 3));
      clk_model();
      checks++; if (int'(count) !== m_cnt || int'(overflow) !== m_ovf ||
                    terminal !== (up ? (m_cnt == MAXV) : (m_cnt == 0)) ||
                    match !== (m_cnt == int'(compare_value))) begin
        errors++; $display("FAIL random%0d got c=%0d o=%0b t=%0b m=%0b want c=%0d o=%0d",
                           i, count, overflow, terminal, match, m_cnt, m_ovf);
      end
    end
    clear = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_saturate_down();
    test_prescaler();
    test_priority();
    test_async_reset();
    test_match();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
